dbus_sub_mem: RTL and testbench
===============================

DBUS_SUB_MEM -- requirements
Module: dbus_sub_mem

Interface
REQ-001 SHALL have parameter MemWords, default 16384, meaning RAM depth in 32-bit words (power of two).
REQ-002 SHALL have parameter MemBase, default 32'h0000_0000, meaning RAM base byte address.
REQ-003 SHALL have parameter MmioBase, default 32'h4000_0000, meaning base of the 32-byte MMIO window.
REQ-004 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port dbus_if  dbus_if.sub  -  subordinate end of the core data bus; consumes addr[31:0], arvalid, wvalid, wdata[31:0] and wstrb[3:0]; drives rdata[31:0].
REQ-007 SHALL have port timer_irq_o  output  1  machine timer interrupt, registered.
REQ-008 SHALL have port tx_valid_o  output  1  one-cycle pulse marking a console byte.
REQ-009 SHALL have port tx_data_o  output  8  console byte, valid while tx_valid_o=1.
REQ-010 SHALL have port tohost_valid_o  output  1  sticky flag: tohost has been written.
REQ-011 SHALL have port tohost_o  output  32  last value written to tohost.
REQ-012 SHALL have port bus_err_o  output  1  sticky flag: an access missed both RAM and MMIO.

Function
REQ-013 SHALL decode RAM hit as MemBase <= addr < MemBase+4*MemWords and MMIO hit as MmioBase <= addr < MmioBase+32; word index = addr[..:2], with addr[1:0] ignored.
REQ-014 SHALL return read data on rdata in the cycle after arvalid=1 (fixed 1-cycle latency, no stall or back-pressure).
REQ-015 SHALL drive rdata=0 in any cycle whose previous cycle had arvalid=0, or had a read that missed both regions.
REQ-016 SHALL commit a write at the rising edge ending the cycle with wvalid=1; only bytes with wstrb[i]=1 change.
REQ-017 SHALL, for arvalid and wvalid together on the same word, return the pre-write data (read-before-write).
REQ-018 SHALL, on a write that misses both regions, change no state and set bus_err_o.
REQ-019 SHALL, on a read that misses both regions, return 0 and set bus_err_o.
REQ-020 SHALL use MMIO offset 0x00 for tohost: a write stores the strobed bytes into tohost_o and sets tohost_valid_o; reads return tohost_o.
REQ-021 SHALL use MMIO offset 0x04 for the console: a write with wstrb[0]=1 pulses tx_valid_o for exactly the next cycle with tx_data_o=wdata[7:0]; reads return 0.
REQ-022 SHALL use MMIO offsets 0x08/0x0C for mtime lo/hi, a 64-bit counter incrementing by 1 every cycle and wrapping 2^64-1 -> 0.
REQ-023 SHALL use MMIO offsets 0x10/0x14 for mtimecmp lo/hi, 64-bit, read/write.
REQ-024 SHALL, on a write to an mtime word, load that word with the strobed value instead of incrementing it; the other word keeps counting, with no carry propagated that cycle.
REQ-025 SHALL treat MMIO offsets 0x18/0x1C as reserved: reads return 0, writes are ignored, bus_err_o is unaffected.
REQ-026 SHALL register timer_irq_o each cycle as (mtime >= mtimecmp), unsigned 64-bit compare on current register values.
REQ-027 SHALL perform a single tx_valid_o pulse per console write; back-to-back writes give back-to-back pulses.

Reset
REQ-028 SHALL, while rst_ni=0, hold rdata=0, timer_irq_o=0, tx_valid_o=0, tx_data_o=0, tohost_valid_o=0, tohost_o=0, bus_err_o=0, mtime=0 and mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, independent of clk_i.
REQ-029 SHALL leave RAM contents unaffected by reset; a reset asserted mid-access discards any in-flight read data and the pending tx pulse.

Verification
REQ-030 SHALL pass: write 0xDEADBEEF to 0x100 with wstrb=4'b1111, then wstrb=4'b0010 with wdata 0x00005500, then read 0x100 -> rdata=0xDEAD55EF exactly 1 cycle after arvalid, and rdata=0 the following idle cycle.
REQ-031 SHALL pass: arvalid and wvalid together to 0x200 holding 0x11111111 with wdata 0x22222222 -> rdata=0x11111111; next read -> 0x22222222.
REQ-032 SHALL pass: write 0x41 to MmioBase+0x04 -> tx_valid_o=1 for one cycle with tx_data_o=0x41; then write 1 to MmioBase+0x00 -> tohost_valid_o=1, tohost_o=1.
REQ-033 SHALL pass: after reset, write mtimecmp lo=20 and hi=0 -> timer_irq_o rises in the cycle after mtime reaches 20; setting mtime lo=0xFFFFFFFF with hi=0 then reading hi 2 cycles later -> 1.
REQ-034 SHALL pass: read 0x8000_0000 -> rdata=0 and bus_err_o=1, held until rst_ni=0.
REQ-035 SHALL pass: assert rst_ni=0 asynchronously between clock edges during a read -> all outputs reach their reset values immediately, and a RAM word written earlier reads back unchanged after reset.

Source files
------------

// File: rtl/dbus_if.sv
// dbus_if -- core data bus between the CPU load/store unit and its memory
// subsystem. The master drives address, read/write strobes and write data;
// the subordinate answers with read data one cycle after a read request.
//
// Signals:
//   addr[31:0]   byte address of the access (bits [1:0] ignored)
//   arvalid      read request this cycle
//   wvalid       write request this cycle
//   wdata[31:0]  write data
//   wstrb[3:0]   byte enables for wdata
//   rdata[31:0]  read data, valid the cycle after arvalid
interface dbus_if;
  logic [31:0] addr;
  logic        arvalid;
  logic        wvalid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;

  modport master (
    output addr, arvalid, wvalid, wdata, wstrb,
    input  rdata
  );

  modport sub (
    input  addr, arvalid, wvalid, wdata, wstrb,
    output rdata
  );
endinterface

// File: rtl/dbus_sub_mem.sv
// dbus_sub_mem -- data-bus subordinate holding a word-addressed RAM and a
// small 32-byte MMIO window (tohost, console, machine timer).
//
// Ports:
//   clk_i           sole clock, rising edge
//   rst_ni          asynchronous active-low reset
//   dbus_if         subordinate end of the core data bus
//   timer_irq_o     registered (mtime >= mtimecmp)
//   tx_valid_o      one-cycle pulse per console byte
//   tx_data_o       console byte, valid with tx_valid_o
//   tohost_valid_o  sticky: tohost has been written
//   tohost_o        last value written to tohost
//   bus_err_o       sticky: an access missed both RAM and MMIO
//
// MMIO map (offset from MmioBase):
//   0x00 tohost   0x04 console   0x08/0x0C mtime lo/hi
//   0x10/0x14 mtimecmp lo/hi     0x18/0x1C reserved (read 0, writes ignored)
module dbus_sub_mem #(
  parameter int unsigned MemWords = 16384,
  parameter logic [31:0] MemBase  = 32'h0000_0000,
  parameter logic [31:0] MmioBase = 32'h4000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  dbus_if.sub         dbus_if,
  output logic        timer_irq_o,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  output logic        tohost_valid_o,
  output logic [31:0] tohost_o,
  output logic        bus_err_o
);

  localparam int unsigned AW       = $clog2(MemWords);
  localparam logic [32:0] RamBytes = 33'(MemWords) << 2;

  typedef enum logic [1:0] {RD_NONE, RD_RAM, RD_MMIO} rd_sel_e;

  // Byte-wise merge of a write into an existing 32-bit register.
  function automatic logic [31:0] merge(input logic [31:0] old_val,
                                        input logic [31:0] new_val,
                                        input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  logic [31:0]   ram [MemWords];
  logic [31:0]   ram_q;
  logic [31:0]   mmio_q;
  logic [31:0]   mmio_rd_val;
  rd_sel_e       rd_sel_q;
  rd_sel_e       rd_sel_d;

  logic [31:0]   ram_off;
  logic [31:0]   mmio_off;
  logic          ram_hit;
  logic          mmio_hit;
  logic          miss;
  logic [AW-1:0] ram_idx;
  logic [2:0]    mmio_sel;
  logic          mmio_wr;

  logic [31:0]   mtime_lo, mtime_hi;
  logic [31:0]   mtime_lo_nxt, mtime_hi_nxt;
  logic [31:0]   mtimecmp_lo, mtimecmp_hi;

  // Address decode. Offsets are computed with wrap-around and then bounded,
  // so a base near the top of the address space still decodes correctly.
  // RAM wins if the two windows were ever configured to overlap.
  assign ram_off  = dbus_if.addr - MemBase;
  assign mmio_off = dbus_if.addr - MmioBase;
  assign ram_hit  = (dbus_if.addr >= MemBase) && ({1'b0, ram_off} < RamBytes);
  assign mmio_hit = (dbus_if.addr >= MmioBase) && (mmio_off < 32'd32) && !ram_hit;
  assign ram_idx  = ram_off[AW+1:2];
  assign mmio_sel = mmio_off[4:2];
  assign miss     = (dbus_if.arvalid || dbus_if.wvalid) && !ram_hit && !mmio_hit;
  assign mmio_wr  = dbus_if.wvalid && mmio_hit;

  // RAM array: deliberately outside the reset domain so contents survive reset.
  // The registered read picks up the old word when a write hits the same
  // address in the same cycle.
  always_ff @(posedge clk_i) begin
    if (dbus_if.wvalid && ram_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (dbus_if.wstrb[i]) ram[ram_idx][8*i +: 8] <= dbus_if.wdata[8*i +: 8];
      end
    end
    if (dbus_if.arvalid && ram_hit) ram_q <= ram[ram_idx];
  end

  // MMIO read mux on current register values (read-before-write).
  always_comb begin
    mmio_rd_val = '0;
    case (mmio_sel)
      3'd0:    mmio_rd_val = tohost_o;
      3'd2:    mmio_rd_val = mtime_lo;
      3'd3:    mmio_rd_val = mtime_hi;
      3'd4:    mmio_rd_val = mtimecmp_lo;
      3'd5:    mmio_rd_val = mtimecmp_hi;
      default: mmio_rd_val = '0;
    endcase
  end

  // Which source drives rdata next cycle; misses and idle cycles give zero.
  always_comb begin
    rd_sel_d = RD_NONE;
    if (dbus_if.arvalid) begin
      if (ram_hit)       rd_sel_d = RD_RAM;
      else if (mmio_hit) rd_sel_d = RD_MMIO;
    end
  end

  // Timer next state. A write to one half loads that half and suppresses the
  // carry between halves for that cycle; the other half keeps counting.
  always_comb begin
    mtime_lo_nxt = mtime_lo + 32'd1;
    mtime_hi_nxt = mtime_hi + {31'd0, &mtime_lo};
    if (mmio_wr && mmio_sel == 3'd2) begin
      mtime_lo_nxt = merge(mtime_lo, dbus_if.wdata, dbus_if.wstrb);
      mtime_hi_nxt = mtime_hi;
    end else if (mmio_wr && mmio_sel == 3'd3) begin
      mtime_hi_nxt = merge(mtime_hi, dbus_if.wdata, dbus_if.wstrb);
    end
  end

  // rdata is gated by the reset-cleared select, so an asserted reset drops any
  // in-flight read data at once without needing to clear the RAM read register.
  assign dbus_if.rdata = (rd_sel_q == RD_RAM)  ? ram_q  :
                         (rd_sel_q == RD_MMIO) ? mmio_q : 32'd0;

  // All resettable state: read select, MMIO registers, timer and flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_sel_q       <= RD_NONE;
      mmio_q         <= '0;
      mtime_lo       <= '0;
      mtime_hi       <= '0;
      mtimecmp_lo    <= '1;
      mtimecmp_hi    <= '1;
      timer_irq_o    <= 1'b0;
      tx_valid_o     <= 1'b0;
      tx_data_o      <= '0;
      tohost_valid_o <= 1'b0;
      tohost_o       <= '0;
      bus_err_o      <= 1'b0;
    end else begin
      rd_sel_q <= rd_sel_d;
      if (dbus_if.arvalid && mmio_hit) mmio_q <= mmio_rd_val;

      mtime_lo    <= mtime_lo_nxt;
      mtime_hi    <= mtime_hi_nxt;
      timer_irq_o <= ({mtime_hi, mtime_lo} >= {mtimecmp_hi, mtimecmp_lo});

      if (mmio_wr && mmio_sel == 3'd4)
        mtimecmp_lo <= merge(mtimecmp_lo, dbus_if.wdata, dbus_if.wstrb);
      if (mmio_wr && mmio_sel == 3'd5)
        mtimecmp_hi <= merge(mtimecmp_hi, dbus_if.wdata, dbus_if.wstrb);

      tx_valid_o <= 1'b0;
      if (mmio_wr && mmio_sel == 3'd1 && dbus_if.wstrb[0]) begin
        tx_valid_o <= 1'b1;
        tx_data_o  <= dbus_if.wdata[7:0];
      end

      if (mmio_wr && mmio_sel == 3'd0) begin
        tohost_o       <= merge(tohost_o, dbus_if.wdata, dbus_if.wstrb);
        tohost_valid_o <= 1'b1;
      end

      if (miss) bus_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dbus_sub_mem.sv
// tb_dbus_sub_mem -- directed self-checking bench for dbus_sub_mem.
// Inputs change 1 ns after a rising edge and outputs are sampled there too.
module tb_dbus_sub_mem;

  localparam logic [31:0] MMIO = 32'h4000_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        timer_irq_o;
  logic        tx_valid_o;
  logic [7:0]  tx_data_o;
  logic        tohost_valid_o;
  logic [31:0] tohost_o;
  logic        bus_err_o;

  int checks = 0;
  int errors = 0;

  dbus_if bus ();

  dbus_sub_mem dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .dbus_if        (bus),
    .timer_irq_o    (timer_irq_o),
    .tx_valid_o     (tx_valid_o),
    .tx_data_o      (tx_data_o),
    .tohost_valid_o (tohost_valid_o),
    .tohost_o       (tohost_o),
    .bus_err_o      (bus_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one rising edge and settle.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Drive one bus cycle and let it complete.
  task automatic cyc(input logic [31:0] addr, input logic rd, input logic wr,
                     input logic [31:0] wdata, input logic [3:0] strb);
    bus.addr    = addr;
    bus.arvalid = rd;
    bus.wvalid  = wr;
    bus.wdata   = wdata;
    bus.wstrb   = strb;
    tick();
    bus.arvalid = 1'b0;
    bus.wvalid  = 1'b0;
  endtask

  task automatic idle();
    cyc(32'h0, 1'b0, 1'b0, 32'h0, 4'h0);
  endtask

  task automatic do_reset();
    bus.arvalid = 1'b0;
    bus.wvalid  = 1'b0;
    rst_ni = 1'b0;
    #12;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #3;
    checks++;
    if (bus.rdata !== 32'h0 || timer_irq_o !== 1'b0 || tx_valid_o !== 1'b0 ||
        tx_data_o !== 8'h0 || tohost_valid_o !== 1'b0 || tohost_o !== 32'h0 ||
        bus_err_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: rdata=%h irq=%b txv=%b txd=%h thv=%b th=%h err=%b, required all zero",
               bus.rdata, timer_irq_o, tx_valid_o, tx_data_o, tohost_valid_o, tohost_o, bus_err_o);
    end
    do_reset();
  endtask

  task automatic test_ram_strobe();
    cyc(32'h100, 1'b0, 1'b1, 32'hDEADBEEF, 4'b1111);
    cyc(32'h100, 1'b0, 1'b1, 32'h00005500, 4'b0010);
    cyc(32'h100, 1'b1, 1'b0, 32'h0, 4'h0);
    checks++;
    if (bus.rdata !== 32'hDEAD55EF) begin
      errors++;
      $display("[TB] FAIL ram_strobe_read: got %h, required %h", bus.rdata, 32'hDEAD55EF);
    end
    idle();
    checks++;
    if (bus.rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL ram_idle_zero: got %h, required 0", bus.rdata);
    end
    // addr[1:0] are ignored
    cyc(32'h103, 1'b1, 1'b0, 32'h0, 4'h0);
    checks++;
    if (bus.rdata !== 32'hDEAD55EF) begin
      errors++;
      $display("[TB] FAIL ram_unaligned: got %h, required %h", bus.rdata, 32'hDEAD55EF);
    end
  endtask

  task automatic test_read_before_write();
    cyc(32'h200, 1'b0, 1'b1, 32'h11111111, 4'b1111);
    cyc(32'h200, 1'b1, 1'b1, 32'h22222222, 4'b1111);
    checks++;
    if (bus.rdata !== 32'h11111111) begin
      errors++;
      $display("[TB] FAIL rbw_old: got %h, required %h", bus.rdata, 32'h11111111);
    end
    cyc(32'h200, 1'b1, 1'b0, 32'h0, 4'h0);
    checks++;
    if (bus.rdata !== 32'h22222222) begin
      errors++;
      $display("[TB] FAIL rbw_new: got %h, required %h", bus.rdata, 32'h22222222);
    end
  endtask

  task automatic test_console_tohost();
    cyc(MMIO + 32'h4, 1'b0, 1'b1, 32'h00000041, 4'b0001);
    checks++;
    if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h41) begin
      errors++;
      $display("[TB] FAIL console_pulse: valid=%b data=%h, required 1/41", tx_valid_o, tx_data_o);
    end
    idle();
    checks++;
    if (tx_valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL console_single: valid=%b, required 0", tx_valid_o);
    end
    checks++;
    if (tohost_valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL tohost_early: valid=%b, required 0", tohost_valid_o);
    end
    cyc(MMIO, 1'b0, 1'b1, 32'h00000001, 4'b1111);
    checks++;
    if (tohost_valid_o !== 1'b1 || tohost_o !== 32'h1) begin
      errors++;
      $display("[TB] FAIL tohost_write: valid=%b value=%h, required 1/00000001", tohost_valid_o, tohost_o);
    end
    cyc(MMIO, 1'b1, 1'b0, 32'h0, 4'h0);
    checks++;
    if (bus.rdata !== 32'h1) begin
      errors++;
      $display("[TB] FAIL tohost_read: got %h, required 00000001", bus.rdata);
    end
  endtask

  task automatic test_back_to_back();
    cyc(MMIO + 32'h4, 1'b0, 1'b1, 32'h00000055, 4'b0001);
    checks++;
    if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h55) begin
      errors++;
      $display("[TB] FAIL b2b_first: valid=%b data=%h, required 1/55", tx_valid_o, tx_data_o);
    end
    cyc(MMIO + 32'h4, 1'b0, 1'b1, 32'h00000066, 4'b0001);
    checks++;
    if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h66) begin
      errors++;
      $display("[TB] FAIL b2b_second: valid=%b data=%h, required 1/66", tx_valid_o, tx_data_o);
    end
    // strobe without byte 0 gives no pulse; console reads are zero
    cyc(MMIO + 32'h4, 1'b1, 1'b1, 32'h00007700, 4'b0010);
    checks++;
    if (tx_valid_o !== 1'b0 || bus.rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL console_nostrb: valid=%b rdata=%h, required 0/0", tx_valid_o, bus.rdata);
    end
  endtask

  task automatic test_reserved();
    cyc(MMIO + 32'h18, 1'b0, 1'b1, 32'hFFFFFFFF, 4'b1111);
    cyc(MMIO + 32'h18, 1'b1, 1'b0, 32'h0, 4'h0);
    checks++;
    if (bus.rdata !== 32'h0 || bus_err_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reserved: rdata=%h err=%b, required 0/0", bus.rdata, bus_err_o);
    end
  endtask

  task automatic test_timer();
    do_reset();
    cyc(MMIO + 32'h10, 1'b0, 1'b1, 32'd20, 4'b1111);
    cyc(MMIO + 32'h14, 1'b0, 1'b1, 32'd0, 4'b1111);
    // now in cycle 2 after reset; mtime equals the cycle number
    for (int n = 3; n <= 22; n++) begin
      idle();
      checks++;
      if (timer_irq_o !== (n >= 21)) begin
        errors++;
        $display("[TB] FAIL timer_irq_cycle%0d: got %b, required %b", n, timer_irq_o, (n >= 21));
      end
    end
    cyc(MMIO + 32'h10, 1'b1, 1'b0, 32'h0, 4'h0);
    checks++;
    if (bus.rdata !== 32'd20) begin
      errors++;
      $display("[TB] FAIL mtimecmp_read: got %h, required 00000014", bus.rdata);
    end
    cyc(MMIO + 32'h0C, 1'b0, 1'b1, 32'h0, 4'b1111);
    cyc(MMIO + 32'h08, 1'b0, 1'b1, 32'hFFFFFFFF, 4'b1111);
    idle();
    cyc(MMIO + 32'h0C, 1'b1, 1'b0, 32'h0, 4'h0);
    checks++;
    if (bus.rdata !== 32'h1) begin
      errors++;
      $display("[TB] FAIL mtime_carry: hi got %h, required 00000001", bus.rdata);
    end
  endtask

  task automatic test_bus_err();
    cyc(32'h8000_0000, 1'b1, 1'b0, 32'h0, 4'h0);
    checks++;
    if (bus.rdata !== 32'h0 || bus_err_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bus_err_read: rdata=%h err=%b, required 0/1", bus.rdata, bus_err_o);
    end
    idle();
    idle();
    checks++;
    if (bus_err_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bus_err_sticky: got %b, required 1", bus_err_o);
    end
  endtask

  task automatic test_async_reset();
    // word 0x100 holds DEAD55EF; catch its read data in flight
    bus.addr = 32'h100; bus.arvalid = 1'b1; bus.wvalid = 1'b0;
    tick();
    bus.arvalid = 1'b0;
    checks++;
    if (bus.rdata !== 32'hDEAD55EF) begin
      errors++;
      $display("[TB] FAIL pre_reset_read: got %h, required %h", bus.rdata, 32'hDEAD55EF);
    end
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if (bus.rdata !== 32'h0 || bus_err_o !== 1'b0 || tohost_valid_o !== 1'b0 ||
        tohost_o !== 32'h0 || timer_irq_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: rdata=%h err=%b thv=%b th=%h irq=%b, required all zero",
               bus.rdata, bus_err_o, tohost_valid_o, tohost_o, timer_irq_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    // pending console pulse is killed by a mid-cycle reset
    cyc(MMIO + 32'h4, 1'b0, 1'b1, 32'h00000077, 4'b0001);
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if (tx_valid_o !== 1'b0 || tx_data_o !== 8'h0) begin
      errors++;
      $display("[TB] FAIL async_reset_tx: valid=%b data=%h, required 0/00", tx_valid_o, tx_data_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    cyc(32'h100, 1'b1, 1'b0, 32'h0, 4'h0);
    checks++;
    if (bus.rdata !== 32'hDEAD55EF) begin
      errors++;
      $display("[TB] FAIL ram_retained: got %h, required %h", bus.rdata, 32'hDEAD55EF);
    end
  endtask

  initial begin
    bus.addr = '0; bus.arvalid = 1'b0; bus.wvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0;
    test_reset();
    test_ram_strobe();
    test_read_before_write();
    test_console_tohost();
    test_back_to_back();
    test_reserved();
    test_timer();
    test_bus_err();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
